// File: rtl/pool_pkg.sv
// Shared state encoding and sizing helpers for the 2x2 max-pool row sequencer.
package pool_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVEN_ROW = 2'd1,
        ST_ODD_ROW  = 2'd2
    } state_t;

    function automatic int col_w(input int row_len);
        return (row_len > 1) ? $clog2(row_len) : 1;
    endfunction

    function automatic int row_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational unsigned two-input maximum; result keeps the input width.
module pool_max2 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_max
);

    assign o_max = (i_a > i_b) ? i_a : i_b;

endmodule

// File: rtl/pool_row_ctrl.sv
// Row sequencer for 2x2 max pooling: forms horizontal pair maxima, feeds them through
// the external shifter_row, and on odd rows merges them with the row above.
module pool_row_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROW_LEN  = 16,
    parameter int NUM_ROWS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sr_ce,
    output logic              sr_rst,
    output logic [DATA_W-1:0] sr_in,
    input  logic [DATA_W-1:0] sr_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = col_w(ROW_LEN);
    localparam int ROW_W = row_w(NUM_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    state_t            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_pair_hold, r_sr_in, r_out_data;
    logic [DATA_W-1:0] w_pair_max, w_vert_max;
    logic              r_sr_ce, r_sr_odd, r_sr_rst, r_out_valid, r_frame_done;
    logic              w_busy, w_accept, w_go, w_col_last, w_row_last;

    assign w_busy     = (r_state != ST_IDLE);
    assign in_ready   = w_busy && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_go       = (r_state == ST_IDLE) && start && !r_out_valid;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    pool_max2 #(.DATA_W(DATA_W)) u_pair_max (
        .i_a   (r_pair_hold),
        .i_b   (in_data),
        .o_max (w_pair_max)
    );

    pool_max2 #(.DATA_W(DATA_W)) u_vert_max (
        .i_a   (r_sr_in),
        .i_b   (sr_out),
        .o_max (w_vert_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_go) w_state_nxt = ST_EVEN_ROW;
            ST_EVEN_ROW: if (w_accept && w_col_last) w_state_nxt = w_row_last ? ST_IDLE : ST_ODD_ROW;
            ST_ODD_ROW:  if (w_accept && w_col_last) w_state_nxt = w_row_last ? ST_IDLE : ST_EVEN_ROW;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // r_sr_odd travels with the pair so the last pair of an odd row still pools
    // after the state has already moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_pair_hold  <= '0;
            r_sr_in      <= '0;
            r_sr_ce      <= 1'b0;
            r_sr_odd     <= 1'b0;
            r_sr_rst     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_sr_rst     <= w_go;
            r_sr_ce      <= w_accept && r_col[0];
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_go) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (!r_col[0]) begin
                    r_pair_hold <= in_data;
                end else begin
                    r_sr_in  <= w_pair_max;
                    r_sr_odd <= (r_state == ST_ODD_ROW);
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // A freshly pooled result takes priority over clearing the accepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (r_sr_ce && r_sr_odd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_vert_max;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sr_ce      = r_sr_ce;
    assign sr_rst     = r_sr_rst;
    assign sr_in      = r_sr_in;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign busy       = w_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_row_ctrl.sv
// Scoreboard bench for pool_row_ctrl: a window-level reference model predicts pair maxima
// and pooled results; a negedge monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_pool_row_ctrl;
    localparam int DW = 8, RL = 4, NR = 2, DEPTH = RL / 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic in_ready, sr_ce, sr_rst, out_valid, busy, frame_done;
    logic [DW-1:0] sr_in, sr_out, out_data;

    pool_row_ctrl #(.DATA_W(DW), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sr_ce(sr_ce), .sr_rst(sr_rst), .sr_in(sr_in), .sr_out(sr_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // External line buffer: oldest entry is presented and displaced on each sr_ce.
    logic [DW-1:0] sh [DEPTH];
    assign sr_out = sh[DEPTH-1];
    always @(posedge clk) begin
        if (sr_rst) begin
            for (int i = 0; i < DEPTH; i++) sh[i] <= '0;
        end else if (sr_ce) begin
            sh[0] <= sr_in;
            for (int i = 1; i < DEPTH; i++) sh[i] <= sh[i-1];
        end
    end

    typedef struct { logic [DW-1:0] d; int cyc; bit chk; } exp_t;
    exp_t q_out[$], q_sr[$];
    logic [DW-1:0] pix [NR][RL];
    logic [DW-1:0] fr [NR*RL];
    int mr = 0, mc = 0, cyc = 0, nvec = 0, nerr = 0, fd_seen = 0, fd_exp = 0;
    bit lat_mode = 1'b1, rnd_rdy = 1'b0, prev_ce = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rnd_rdy) begin
        #1 out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_accept(input logic [DW-1:0] v);
        exp_t e;
        pix[mr][mc] = v;
        if (mc % 2 == 1) begin
            e.d = max2(pix[mr][mc-1], v); e.cyc = cyc + 1; e.chk = 1'b1;
            q_sr.push_back(e);
            if (mr % 2 == 1) begin
                e.d = max2(e.d, max2(pix[mr-1][mc-1], pix[mr-1][mc]));
                e.cyc = cyc + 2; e.chk = lat_mode;
                q_out.push_back(e);
            end
        end
        if (mc == RL - 1) begin
            mc = 0;
            if (mr == NR - 1) begin mr = 0; fd_exp++; end
            else mr++;
        end else mc++;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (in_valid && in_ready) model_accept(in_data);
            if (sr_ce) begin
                nvec++;
                if (prev_ce) begin nerr++; $display("FAIL sr_ce_isolated cyc=%0d got back-to-back pulse, required gap", cyc); end
                nvec++;
                if (q_sr.size() == 0) begin
                    nerr++; $display("FAIL sr_in_unexpected cyc=%0d got pulse with %0d, required none", cyc, sr_in);
                end else begin
                    e = q_sr.pop_front();
                    if (sr_in !== e.d || cyc != e.cyc) begin
                        nerr++; $display("FAIL sr_in got %0d@%0d required %0d@%0d", sr_in, cyc, e.d, e.cyc);
                    end
                end
            end
            if (out_valid && out_ready) begin
                nvec++;
                if (q_out.size() == 0) begin
                    nerr++; $display("FAIL out_unexpected cyc=%0d got %0d, required none", cyc, out_data);
                end else begin
                    e = q_out.pop_front();
                    if (out_data !== e.d || (e.chk && cyc != e.cyc)) begin
                        nerr++; $display("FAIL out_data got %0d@%0d required %0d@%0d", out_data, cyc, e.d, e.cyc);
                    end
                end
            end
            if (frame_done) fd_seen++;
            prev_ce = sr_ce;
        end else prev_ce = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin nerr++; $display("FAIL %s got %0d required %0d", nm, got, req); end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [DW-1:0] v, input int gap);
        int t = 0;
        in_valid = 1'b1; in_data = v;
        @(negedge clk);
        while (!in_ready && t < 100) begin t++; @(negedge clk); end
        if (t >= 100) begin nvec++; nerr++; $display("FAIL send_timeout got no in_ready, required accept of %0d", v); end
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_frame();
        int t = 0;
        while ((busy || out_valid) && t < 200) begin tick(); t++; end
        if (t >= 200) begin nvec++; nerr++; $display("FAIL start_wait got busy=%0d out_valid=%0d, required idle", busy, out_valid); end
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic end_frame();
        int t = 0;
        while ((busy || q_out.size() != 0) && t < 300) begin tick(); t++; end
        repeat (3) tick();
        chk("frame_drain", q_out.size(), 0);
        chk("frame_done_count", fd_seen, fd_exp);
        chk("end_busy", busy, 0);
    endtask

    task automatic run_frame(input int gap);
        start_frame();
        for (int i = 0; i < NR*RL; i++) send(fr[i], (gap < 0) ? $urandom_range(0, 2) : gap);
        end_frame();
    endtask

    task automatic load(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
        fr[0] = a0; fr[1] = a1; fr[2] = a2; fr[3] = a3;
        fr[4] = b0; fr[5] = b1; fr[6] = b2; fr[7] = b3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0); chk("rst_sr_rst", sr_rst, 1);
        chk("rst_busy", busy, 0); chk("rst_sr_ce", sr_ce, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("rel_sr_rst_held", sr_rst, 1);
        tick();
        chk("rel_sr_rst_clear", sr_rst, 0);

        // Basic frame, then the same with every-other-cycle input.
        load(1, 5, 3, 2, 4, 0, 7, 9);
        run_frame(0);
        run_frame(1);

        // Back-pressure on the row-1 results.
        lat_mode = 1'b0;
        start_frame();
        for (int i = 0; i < RL; i++) send(fr[i], 0);
        out_ready = 1'b0;
        send(4, 0); send(0, 0); send(7, 0);
        in_valid = 1'b1; in_data = 9;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0); chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 5);
        end
        tick(); out_ready = 1'b1;
        send(9, 0);
        out_ready = 1'b0;
        while (busy) tick();
        repeat (3) tick();
        chk("pend_out_valid", out_valid, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_pending", busy, 0);
        out_ready = 1'b1;
        end_frame();
        lat_mode = 1'b1;

        // Reset after the third pixel of row 1.
        start_frame();
        for (int i = 0; i < RL; i++) send(fr[i], 0);
        send(4, 0); send(0, 0); send(7, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sr_ce", sr_ce, 0); chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0); chk("mid_rst_sr_in", sr_in, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_sr_rst", sr_rst, 1); chk("mid_rst_frame_done", frame_done, 0);
        q_out.delete(); q_sr.delete(); mr = 0; mc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("mid_rel_sr_rst_held", sr_rst, 1);
        tick();
        chk("mid_rel_sr_rst_clear", sr_rst, 0);
        run_frame(0);

        // in_valid while idle, then start pulsed mid-frame.
        in_valid = 1'b1; in_data = 77;
        repeat (4) begin @(negedge clk); chk("idle_in_ready", in_ready, 0); chk("idle_busy", busy, 0); end
        tick(); in_valid = 1'b0;
        start_frame();
        for (int i = 0; i < NR*RL; i++) begin
            if (i == 3) start = 1'b1;
            send(fr[i], 0);
            start = 1'b0;
        end
        end_frame();

        // Value extremes.
        load(255, 255, 0, 0, 0, 0, 255, 0);
        run_frame(0);

        // Randomized frames with random gaps and back-pressure.
        lat_mode = 1'b0; rnd_rdy = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NR*RL; i++)
                fr[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom_range(0, 255));
            run_frame(-1);
        end
        rnd_rdy = 1'b0; tick(); out_ready = 1'b1;
        repeat (5) tick();
        chk("final_out_queue", q_out.size(), 0);
        chk("final_sr_queue", q_sr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
